// File: rtl/reg_commit_sched_pkg.sv
// reg_sched_pkg: shared widths, FSM state encoding and commit entry layout for reg_commit_sched
package reg_sched_pkg;
  localparam int REG_ADDR_WIDTH_D = 5;
  localparam int Q_WIDTH_D = 5;
  localparam int FIFO_DEPTH_D = 4;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
  typedef struct packed {
    logic [REG_ADDR_WIDTH_D-1:0] rd;
    logic [Q_WIDTH_D-1:0]        tag;
    logic [DATA_WIDTH-1:0]       value;
  } commit_entry_t;
endpackage

// File: rtl/reg_commit_sched_if.sv
// reg_commit_sched_if: commit, issue and regfile write-port bundle; slave is the scheduler side
interface reg_commit_sched_if #(
  parameter int RA = 5,
  parameter int QW = 5
);
  logic          cm_valid;
  logic          cm_ready;
  logic [RA-1:0] cm_rd;
  logic [QW-1:0] cm_tag;
  logic [31:0]   cm_value;
  logic          issue_valid;
  logic          issue_ready;
  logic [RA-1:0] issue_rd;
  logic [QW-1:0] issue_tag;
  logic          has_commit;
  logic [RA-1:0] commit_target;
  logic [QW-1:0] Commit_Q;
  logic [31:0]   Commit_V;
  logic          rd_control;
  logic [RA-1:0] rd;
  logic [QW-1:0] Q_value;
  modport master (
    output cm_valid, cm_rd, cm_tag, cm_value, issue_valid, issue_rd, issue_tag,
    input  cm_ready, issue_ready, has_commit, commit_target, Commit_Q, Commit_V,
           rd_control, rd, Q_value
  );
  modport slave (
    input  cm_valid, cm_rd, cm_tag, cm_value, issue_valid, issue_rd, issue_tag,
    output cm_ready, issue_ready, has_commit, commit_target, Commit_Q, Commit_V,
           rd_control, rd, Q_value
  );
endinterface

// File: rtl/reg_commit_fifo.sv
// reg_commit_fifo: synchronous FIFO with full/empty flags, head visible combinationally
module reg_commit_fifo #(
  parameter int W = 42,
  parameter int DEPTH = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout = mem_q[rd_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // pointer advance and entry write; the extra pointer bit separates full from empty
  always_comb begin
    mem_d = mem_q;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = din;
  end
  // storage and pointer registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_q <= '0;
      rd_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/reg_commit_sched.sv
// reg_commit_sched: owns both regfile write ports; buffers commits, gates renames, sweeps Q tags after flush (REG_COMMIT_BYPASS_EN: zero-latency commit when idle)
module reg_commit_sched
  import reg_sched_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_D,
  parameter int Q_WIDTH = Q_WIDTH_D,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic flush_in,
  output logic busy,
  reg_commit_sched_if.slave bus
);
  localparam int EW = REG_ADDR_WIDTH + Q_WIDTH + DATA_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] LAST = '1;
  state_t                    state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                      full, empty, push, pop, byp, run, clr;
  logic [EW-1:0]             head;
  assign run = state_q == RUN;
  assign clr = state_q == CLEAR;
  assign busy = !run;
  reg_commit_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .push  (push),
    .pop   (pop),
    .din   ({bus.cm_rd, bus.cm_tag, bus.cm_value}),
    .full  (full),
    .empty (empty),
    .dout  (head)
  );
  // handshakes, commit port muxing (bypass or FIFO head) and rename/sweep port muxing
  always_comb begin
`ifdef REG_COMMIT_BYPASS_EN
    byp = run && rdy_in && empty && bus.cm_valid && bus.cm_rd != '0;
`else
    byp = 1'b0;
`endif
    bus.cm_ready = run && !full && rdy_in;
    push = bus.cm_valid && bus.cm_ready && bus.cm_rd != '0 && !byp;
    pop = !empty && rdy_in;
    bus.has_commit = pop || byp;
    {bus.commit_target, bus.Commit_Q, bus.Commit_V} =
      byp ? {bus.cm_rd, bus.cm_tag, bus.cm_value} : pop ? head : '0;
    bus.issue_ready = run && rdy_in;
    bus.rd_control = clr ? rdy_in : bus.issue_valid && bus.issue_ready && bus.issue_rd != '0;
    bus.rd = clr ? cnt_q : bus.issue_rd;
    bus.Q_value = clr ? '0 : bus.issue_tag;
  end
  // flush sequencing: drain buffered commits, then sweep x1..x(N-1); everything freezes when rdy_in is low
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (rdy_in) begin
      case (state_q)
        RUN: state_d = flush_in ? DRAIN : RUN;
        DRAIN: begin
          state_d = empty ? CLEAR : DRAIN;
          cnt_d = empty ? REG_ADDR_WIDTH'(1) : cnt_q;
        end
        CLEAR: begin
          state_d = cnt_q == LAST ? RUN : CLEAR;
          cnt_d = cnt_q + 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end
  // FSM state and sweep counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_reg_commit_sched.sv
// tb_reg_commit_sched: directed checks of commit buffering, rename gating, flush drain/sweep, freeze and reset
module tb_reg_commit_sched;
  import reg_sched_pkg::*;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_in, busy;
  int checks = 0;
  int errors = 0;
  int busy_cnt;
  commit_entry_t ent [5];
  reg_commit_sched_if #(.RA(5), .QW(5)) bus ();
  reg_commit_sched dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .flush_in(flush_in),
    .busy    (busy),
    .bus     (bus)
  );
  always #5 clk_in = ~clk_in;
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask
  task automatic mid();
    @(negedge clk_in);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cm(input logic v, input logic [4:0] r, input logic [4:0] t, input logic [31:0] val);
    bus.cm_valid = v;
    bus.cm_rd = r;
    bus.cm_tag = t;
    bus.cm_value = val;
  endtask
  task automatic iss(input logic v, input logic [4:0] r, input logic [4:0] t);
    bus.issue_valid = v;
    bus.issue_rd = r;
    bus.issue_tag = t;
  endtask
  initial begin
    for (int i = 0; i < 5; i++) ent[i] = '{rd: 5'(7 + i), tag: 5'(1 + i), value: 32'(100 + i)};
    rst_in = 1'b1;
    rdy_in = 1'b1;
    flush_in = 1'b0;
    cm(0, 0, 0, 0);
    iss(0, 0, 0);
    mid();
    chk("rst_busy", busy, 0);
    chk("rst_has_commit", bus.has_commit, 0);
    chk("rst_rd_control", bus.rd_control, 0);
    chk("rst_data", {bus.commit_target, bus.Commit_Q, bus.Commit_V, bus.rd, bus.Q_value}, 0);
    cyc();
    rst_in = 1'b0;
    mid();
    chk("post_rst_cm_ready", bus.cm_ready, 1);
    chk("post_rst_issue_ready", bus.issue_ready, 1);
    // single commit: one cycle latency, one cycle wide
    cyc();
    cm(1, 5, 3, 32'hDEAD);
    mid();
    chk("t1_not_yet", bus.has_commit, 0);
    cyc();
    cm(0, 0, 0, 0);
    mid();
    chk("t1_has_commit", bus.has_commit, 1);
    chk("t1_target", bus.commit_target, 5);
    chk("t1_q", bus.Commit_Q, 3);
    chk("t1_v", bus.Commit_V, 32'hDEAD);
    cyc();
    mid();
    chk("t1_one_cycle", bus.has_commit, 0);
    // five back-to-back commits: drained as fast as accepted, so the buffer never fills
    for (int i = 0; i < 5; i++) begin
      cyc();
      cm(1, ent[i].rd, ent[i].tag, ent[i].value);
      mid();
      chk("t2_cm_ready", bus.cm_ready, 1);
      if (i > 0) begin
        chk("t2_has_commit", bus.has_commit, 1);
        chk("t2_entry", {bus.commit_target, bus.Commit_Q, bus.Commit_V}, ent[i-1]);
      end
    end
    cyc();
    cm(0, 0, 0, 0);
    mid();
    chk("t2_last_entry", {bus.has_commit, bus.commit_target, bus.Commit_Q, bus.Commit_V}, {1'b1, ent[4]});
    cyc();
    mid();
    chk("t2_drained", bus.has_commit, 0);
    // x0 commit discarded; x0 rename accepted but not written; normal rename
    cyc();
    cm(1, 0, 9, 1234);
    mid();
    chk("t3_cm_ready_x0", bus.cm_ready, 1);
    cyc();
    cm(0, 0, 0, 0);
    iss(1, 0, 4);
    mid();
    chk("t3_x0_no_commit", bus.has_commit, 0);
    chk("t3_issue_ready", bus.issue_ready, 1);
    chk("t3_x0_no_rename", bus.rd_control, 0);
    cyc();
    iss(1, 6, 7);
    mid();
    chk("t3_rename", {bus.rd_control, bus.rd, bus.Q_value}, {1'b1, 5'd6, 5'd7});
    // flush: one commit in flight plus one accepted with the flush, then the sweep
    cyc();
    iss(0, 0, 0);
    cm(1, 12, 2, 32'h1111);
    mid();
    cyc();
    cm(1, 13, 4, 32'h2222);
    flush_in = 1'b1;
    mid();
    chk("t4_pre_busy", busy, 0);
    chk("t4_first", {bus.has_commit, bus.commit_target, bus.Commit_V}, {1'b1, 5'd12, 32'h1111});
    cyc();
    cm(0, 0, 0, 0);
    flush_in = 1'b0;
    iss(1, 3, 9);
    busy_cnt = 0;
    mid();
    busy_cnt += int'(busy);
    chk("t4_second", {bus.has_commit, bus.commit_target, bus.Commit_Q, bus.Commit_V}, {1'b1, 5'd13, 5'd4, 32'h2222});
    chk("t4_drain_issue_ready", bus.issue_ready, 0);
    chk("t4_drain_rd_control", bus.rd_control, 0);
    cyc();
    mid();
    busy_cnt += int'(busy);
    chk("t4_drain_empty", {bus.has_commit, bus.rd_control}, 0);
    for (int k = 1; k < 32; k++) begin
      cyc();
      mid();
      busy_cnt += int'(busy);
      chk("t4_sweep", {bus.rd_control, bus.rd, bus.Q_value, bus.issue_ready}, {1'b1, 5'(k), 5'd0, 1'b0});
    end
    cyc();
    mid();
    chk("t4_busy_cycles", busy_cnt, 33);
    chk("t4_back_to_run", {busy, bus.issue_ready}, 2'b01);
    chk("t4_rename_after", {bus.rd_control, bus.rd, bus.Q_value}, {1'b1, 5'd3, 5'd9});
    // empty flush, freeze for three cycles mid-sweep, then resume at the same register
    cyc();
    iss(0, 0, 0);
    flush_in = 1'b1;
    mid();
    cyc();
    flush_in = 1'b0;
    mid();
    chk("t5_drain", {busy, bus.rd_control}, 2'b10);
    for (int k = 1; k < 5; k++) begin
      cyc();
      mid();
      chk("t5_sweep", {bus.rd_control, bus.rd}, {1'b1, 5'(k)});
    end
    cyc();
    rdy_in = 1'b0;
    cm(1, 8, 1, 5);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("t5_frozen", {busy, bus.rd_control, bus.has_commit, bus.cm_ready, bus.issue_ready}, 5'b10000);
      cyc();
    end
    rdy_in = 1'b1;
    cm(0, 0, 0, 0);
    mid();
    chk("t5_resume", {bus.rd_control, bus.rd}, {1'b1, 5'd5});
    cyc();
    mid();
    chk("t5_advance", {bus.rd_control, bus.rd}, {1'b1, 5'd6});
    // asynchronous reset mid-sweep
    #1;
    rst_in = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rd_control", bus.rd_control, 0);
    chk("t6_rst_has_commit", bus.has_commit, 0);
    cyc();
    rst_in = 1'b0;
    mid();
    chk("t6_after_rst", {busy, bus.cm_ready, bus.issue_ready, bus.has_commit}, 4'b0110);
`ifdef REG_COMMIT_BYPASS_EN
    cyc();
    cm(1, 20, 6, 32'hBEEF);
    mid();
    chk("t6_bypass", {bus.has_commit, bus.commit_target, bus.Commit_Q, bus.Commit_V}, {1'b1, 5'd20, 5'd6, 32'hBEEF});
    cyc();
    cm(0, 0, 0, 0);
    mid();
    chk("t6_bypass_not_queued", bus.has_commit, 0);
`else
    cyc();
    cm(1, 20, 6, 32'hBEEF);
    mid();
    chk("t6_buffered", bus.has_commit, 0);
    cyc();
    cm(0, 0, 0, 0);
    mid();
    chk("t6_buffered_out", {bus.has_commit, bus.commit_target, bus.Commit_Q, bus.Commit_V}, {1'b1, 5'd20, 5'd6, 32'hBEEF});
`endif
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
